// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine.
// Takes the EX/MEM register outputs and turns a sized load or store into one
// handshaked, word-wide data-memory transaction. Stores get byte enables and
// lane replication. Loads get lane extraction and sign or zero extension.
// The unit stalls the pipeline until the transaction completes. Non-memory
// instructions pass through to MEM/WB combinationally.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   MemWrite/MemRead  : 00 none, 01 byte, 10 half, 11 word
//   ld_unsigned       : zero-extend (1) or sign-extend (0) sub-word loads
//   MemtoReg/RegWrite/rd/Aluout/busB : EX/MEM payload
//   dm_*              : data-memory request/ack bus
//   mem_stall         : freezes the upstream pipeline registers
//   wb_*              : results presented to MEM/WB
//   addr_err/bus_err  : one-cycle error pulses (misaligned / ack timeout)
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MemWrite,
  input  logic [1:0]  MemRead,
  input  logic        ld_unsigned,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [4:0]  rd,
  input  logic [31:0] Aluout,
  input  logic [31:0] busB,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      ld_q, ld_d;
  logic             err_q, err_d;
  logic             aerr_q, aerr_d;
  logic             berr_q, berr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Load shape captured at request time so extraction does not depend on
  // the upstream inputs during the ack cycle.
  logic [1:0]       off_q, off_d;
  logic [1:0]       lsize_q, lsize_d;
  logic             uns_q, uns_d;

  logic        is_wr_c;
  logic        access_c;
  logic [1:0]  size_c;
  logic        misalign_c;
  logic [31:0] st_wdata_c;
  logic [3:0]  st_be_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] ext_c;

  // Request decode: a write takes precedence over a simultaneous read.
  always_comb begin
    is_wr_c    = (MemWrite != 2'b00);
    access_c   = is_wr_c || (MemRead != 2'b00);
    size_c     = is_wr_c ? MemWrite : MemRead;
    misalign_c = 1'b0;
    case (size_c)
      2'b10:   misalign_c = Aluout[0];
      2'b11:   misalign_c = (Aluout[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    st_wdata_c = '0;
    st_be_c    = '0;
    case (MemWrite)
      2'b01: begin
        st_wdata_c = {4{busB[7:0]}};
        st_be_c    = 4'b0001 << Aluout[1:0];
      end
      2'b10: begin
        st_wdata_c = {2{busB[15:0]}};
        st_be_c    = Aluout[1] ? 4'b1100 : 4'b0011;
      end
      2'b11: begin
        st_wdata_c = busB;
        st_be_c    = 4'b1111;
      end
      default: begin
        st_wdata_c = '0;
        st_be_c    = '0;
      end
    endcase
  end

  // Load lane extraction and extension; lsize_q==00 marks "no load data".
  always_comb begin
    byte_c = dm_rdata[{off_q, 3'b000} +: 8];
    half_c = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ext_c  = '0;
    case (lsize_q)
      2'b01:   ext_c = uns_q ? {24'b0, byte_c} : {{24{byte_c[7]}}, byte_c};
      2'b10:   ext_c = uns_q ? {16'b0, half_c} : {{16{half_c[15]}}, half_c};
      2'b11:   ext_c = dm_rdata;
      default: ext_c = '0;
    endcase
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    err_d   = err_q;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    cnt_d   = cnt_q;
    off_d   = off_q;
    lsize_d = lsize_q;
    uns_d   = uns_q;

    case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          if (misalign_c) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            aerr_d  = 1'b1;
            ld_d    = '0;
          end else begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = is_wr_c;
            addr_d  = {Aluout[31:2], 2'b00};
            be_d    = is_wr_c ? st_be_c : 4'b1111;
            wdata_d = is_wr_c ? st_wdata_c : 32'b0;
            cnt_d   = '0;
            err_d   = 1'b0;
            off_d   = Aluout[1:0];
            lsize_d = is_wr_c ? 2'b00 : MemRead;
            uns_d   = ld_unsigned;
          end
        end
      end

      ST_REQ: begin
        if (dm_ack) begin
          ld_d    = ext_c;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ld_d    = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
      off_q   <= '0;
      lsize_q <= '0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      lsize_q <= lsize_d;
      uns_q   <= uns_d;
    end
  end

  // Stall is combinational so a new access freezes the pipe in its first cycle.
  always_comb begin
    mem_stall   = 1'b0;
    wb_regwrite = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_stall   = access_c;
        wb_regwrite = access_c ? 1'b0 : RegWrite;
      end
      ST_REQ: begin
        mem_stall   = 1'b1;
        wb_regwrite = 1'b0;
      end
      ST_DONE: begin
        mem_stall   = 1'b0;
        wb_regwrite = RegWrite & ~err_q;
      end
      default: begin
        mem_stall   = 1'b0;
        wb_regwrite = 1'b0;
      end
    endcase
  end

  assign wb_rd    = rd;
  assign wb_data  = MemtoReg ? ld_q : Aluout;

  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_be    = be_q;
  assign dm_wdata = wdata_q;
  assign addr_err = aerr_q;
  assign bus_err  = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized
// loads/stores, checked against a byte-level reference model.
module tb_mem_access_unit;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  MemWrite, MemRead;
  logic        ld_unsigned, MemtoReg, RegWrite;
  logic [4:0]  rd;
  logic [31:0] Aluout, busB;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        mem_stall, wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        addr_err, bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemWrite(MemWrite), .MemRead(MemRead), .ld_unsigned(ld_unsigned),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .rd(rd),
    .Aluout(Aluout), .busB(busB),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data), .addr_err(addr_err), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one instruction and follows it to completion. ack_delay is the
  // number of request cycles that pass before the memory acks (large = never).
  task automatic run_op(input logic [1:0] mw, input logic [1:0] mr,
                        input logic uns, input logic m2r, input logic rw,
                        input logic [4:0] rdv, input logic [31:0] alu,
                        input logic [31:0] bb, input logic [31:0] rdata,
                        input int ack_delay);
    logic        is_wr, is_rd, acc, mis, tmo, done;
    logic [1:0]  sz;
    int          nb, off, stall, reqc, exp_req, exp_stall;
    logic [63:0] v;
    logic [31:0] exp_addr, exp_wd, exp_ld, exp_wb;
    logic [3:0]  exp_be;
    logic        exp_rw;

    // Reference model
    is_wr = (mw != 2'b00);
    is_rd = (mr != 2'b00) && !is_wr;
    acc   = (mw != 2'b00) || (mr != 2'b00);
    sz    = is_wr ? mw : mr;
    nb    = (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    off   = int'(alu % 4);
    mis   = acc && ((off % nb) != 0);
    tmo   = acc && !mis && (ack_delay >= int'(TO));
    exp_addr = alu & ~32'h3;
    exp_be   = is_wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    exp_wd   = '0;
    if (is_wr)
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = bb[8*(i % nb) +: 8];
    if (nb == 4) begin
      exp_ld = rdata;
    end else begin
      v = ({32'b0, rdata} >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
      if (!uns && (((v >> (8 * nb - 1)) & 64'd1) != 64'd0)) v = v - (64'd1 << (8 * nb));
      exp_ld = v[31:0];
    end
    if (!is_rd || tmo) exp_ld = '0;
    exp_req   = tmo ? int'(TO) : ack_delay + 1;
    exp_stall = !acc ? 0 : mis ? 1 : exp_req + 1;
    if (!acc || mis) exp_req = 0;
    exp_rw = (acc && (mis || tmo)) ? 1'b0 : rw;
    exp_wb = m2r ? exp_ld : alu;

    @(negedge clk);
    MemWrite = mw; MemRead = mr; ld_unsigned = uns; MemtoReg = m2r;
    RegWrite = rw; rd = rdv; Aluout = alu; busB = bb;
    dm_ack = 1'b0; dm_rdata = $urandom;
    #1;
    stall = 0; reqc = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        #1;
      end
      if (mem_stall) begin
        stall++;
        chk("err_pulse_while_stalled", {30'b0, addr_err, bus_err}, 32'd0);
        if (dm_req) begin
          reqc++;
          chk("dm_addr", dm_addr, exp_addr);
          chk("dm_be", 32'(dm_be), 32'(exp_be));
          chk("dm_we", 32'(dm_we), 32'(is_wr));
          if (is_wr) chk("dm_wdata", dm_wdata, exp_wd);
          if (reqc == ack_delay + 1) begin
            dm_ack = 1'b1; dm_rdata = rdata;
          end else begin
            dm_ack = 1'b0; dm_rdata = $urandom;
          end
        end else begin
          // Ack noise outside a request must be ignored
          dm_ack = 1'($urandom_range(0, 1)); dm_rdata = $urandom;
        end
      end else begin
        done = 1'b1;
        chk("stall_cycles", 32'(stall), 32'(exp_stall));
        chk("req_cycles", 32'(reqc), 32'(exp_req));
        chk("dm_req_low_at_end", 32'(dm_req), 32'd0);
        chk("wb_rd", 32'(wb_rd), 32'(rdv));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(exp_rw));
        if (!mis) chk("wb_data", wb_data, exp_wb);
        chk("addr_err", 32'(addr_err), 32'(mis));
        chk("bus_err", 32'(bus_err), 32'(tmo));
        dm_ack = 1'($urandom_range(0, 1));
      end
    end
    if (!done) chk("completion_bound", 32'd0, 32'd1);
  endtask

  initial begin
    logic [1:0]  r_mw, r_mr;
    logic        r_m2r, r_rw, r_uns;
    logic [31:0] r_alu;
    int          r_kind, r_sel, r_dly;

    reset = 1'b1; MemWrite = '0; MemRead = '0; ld_unsigned = 1'b0;
    MemtoReg = 1'b0; RegWrite = 1'b0; rd = '0; Aluout = '0; busB = '0;
    dm_rdata = '0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_be", 32'(dm_be), 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_errs", {30'b0, addr_err, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // sb to byte lane 3
    run_op(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd3, 32'h0000_1003, 32'hA5A5_12EF, 32'h0, 0);
    // half loads from upper half, signed then unsigned
    run_op(2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0);
    run_op(2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0);
    // word load with a slow ack
    run_op(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 5);
    // misaligned word load
    run_op(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_3002, 32'h0, 32'h1234_5678, 0);
    // no ack at all, followed by a plain ALU op
    run_op(2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h0, 32'h1111_2222, 1000);
    run_op(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0066, 32'h0, 32'h0, 0);
    // store and load together: store wins, load data reads as zero
    run_op(2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_6004, 32'hCAFE_F00D, 32'h7777_7777, 1);

    // Reset during the second request cycle
    @(negedge clk);
    MemWrite = 2'b00; MemRead = 2'b11; MemtoReg = 1'b1; RegWrite = 1'b1;
    rd = 5'd8; Aluout = 32'h0000_4000; dm_ack = 1'b0;
    #1 chk("rstreq_idle_stall", 32'(mem_stall), 32'd1);
    @(negedge clk);
    #1 chk("rstreq_req1", 32'(dm_req), 32'd1);
    @(negedge clk);
    #1 chk("rstreq_req2", 32'(dm_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemRead = 2'b00; MemtoReg = 1'b0; RegWrite = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rstreq_dm_req", 32'(dm_req), 32'd0);
    chk("rstreq_dm_we", 32'(dm_we), 32'd0);
    chk("rstreq_dm_addr", dm_addr, 32'd0);
    chk("rstreq_dm_be", 32'(dm_be), 32'd0);
    chk("rstreq_dm_wdata", dm_wdata, 32'd0);
    chk("rstreq_stall", 32'(mem_stall), 32'd0);
    chk("rstreq_errs", {30'b0, addr_err, bus_err}, 32'd0);
    @(negedge clk);
    dm_ack = 1'b0;
    #1;
    chk("late_ack_dm_req", 32'(dm_req), 32'd0);
    chk("late_ack_stall", 32'(mem_stall), 32'd0);
    chk("late_ack_errs", {30'b0, addr_err, bus_err}, 32'd0);

    // ALU pass-through
    run_op(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055, 32'h0, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      r_kind = $urandom_range(0, 3);
      r_mw = 2'b00; r_mr = 2'b00; r_m2r = 1'b0;
      r_rw = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      case (r_kind)
        1: r_mw = 2'($urandom_range(1, 3));
        2: begin r_mr = 2'($urandom_range(1, 3)); r_m2r = 1'b1; end
        3: begin
          r_mw = 2'($urandom_range(1, 3)); r_mr = 2'($urandom_range(1, 3));
          r_m2r = 1'($urandom_range(0, 1));
        end
        default: ;
      endcase
      r_alu = $urandom;
      if ($urandom_range(0, 1) == 0) r_alu = r_alu & ~32'h3;
      r_sel = $urandom_range(0, 9);
      r_dly = (r_sel < 6) ? r_sel % 3 : (r_sel == 6) ? int'(TO) - 1 : (r_sel == 7) ? int'(TO) : 1000;
      run_op(r_mw, r_mr, r_uns, r_m2r, r_rw, 5'($urandom), r_alu, $urandom, $urandom, r_dly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
